fp_alu_engine: RTL and testbench

Parametrised, handshaked successor to the single-cycle floating-point ALU top: accepts single-precision (IEEE-754 binary32) operation commands over a valid/ready interface, sequences them through the existing `add_sub`, `multiplier` and `divider` units with per-unit configurable settle latency, and buffers tagged results in an output FIFO. It adds min/max operations, per-result and sticky exception flags, and backpressure. It sits between a command source (instruction loader or host bus) and result consumers such as the hex display path.

---
 rtl/fp_alu_pkg.sv | 44 ++++
 rtl/fp_alu_engine_fifo.sv | 48 ++++
 rtl/fp_alu_units.sv | 113 +++++++++++
 rtl/fp_alu_engine.sv | 150 +++++++++++++++
 tb/tb_fp_alu_engine.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fp_alu_pkg.sv
// Shared types, op encodings and IEEE-754 binary32 helpers for the fp_alu_engine slice.
package fp_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MIN = 3'b100;
  localparam logic [2:0] OP_MAX = 3'b101;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic {IDLE, EXEC} state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        exc;
    logic        zdiv;
  } entry_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  // Subnormals are flushed, so a zero exponent counts as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return !(|x[30:23]);
  endfunction

  // {exc, value}: m[23] is the hidden one; overflow saturates to inf, underflow flushes to zero.
  function automatic logic [32:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [23:0] m);
    logic [32:0] r;
    if (e >= 11'sd255)    r = {1'b1, s, 8'hFF, 23'd0};
    else if (e <= 11'sd0) r = {1'b0, s, 31'd0};
    else                  r = {1'b0, s, e[7:0], m[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/fp_alu_engine_fifo.sv
// fp_result_fifo: DEPTH-entry first-word-fall-through FIFO of result entries.
module fp_result_fifo import fp_alu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;
endmodule

// File: rtl/fp_alu_units.sv
// Combinational add_sub / multiplier / divider units (truncating, subnormals flushed).
module add_sub import fp_alu_pkg::*; (
  input  logic        reset,
  input  logic        control,
  input  logic        addsub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exc
);
  logic [31:0] bx, big, sml;
  logic [7:0]  d;
  logic [26:0] mb, ms, ms_sh, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic signed [10:0] e;
  logic [32:0] pk;
  logic        unused_bits;

  always_comb begin
    bx = {b[31] ^ addsub, b[30:0]};
    if (bx[30:0] > a[30:0]) begin big = bx; sml = a;  end
    else                    begin big = a;  sml = bx; end
    mb    = is_zero(big) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    ms    = is_zero(sml) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d     = big[30:23] - sml[30:23];
    ms_sh = (d > 8'd26) ? 27'd0 : (ms >> d);
    sum   = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms_sh}) : ({1'b0, mb} - {1'b0, ms_sh});
    lz    = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    norm  = sum[26:0] << lz;
    e     = $signed({3'b000, big[30:23]});
    unused_bits = ^norm[2:0];
    if (is_nan(a) || is_nan(bx))                                 pk = {1'b1, FP_QNAN};
    else if (is_inf(a) && is_inf(bx) && (a[31] != bx[31]))       pk = {1'b1, FP_QNAN};
    else if (is_inf(a) || is_inf(bx))                            pk = {1'b0, big};
    else if (sum[27])                                            pk = fp_pack(big[31], e + 11'sd1, sum[27:4]);
    else if (sum == 28'd0)                                       pk = 33'd0;
    else pk = fp_pack(big[31], e - $signed({6'd0, lz}), norm[26:3]);
  end

  assign result = (reset || !control) ? 32'd0 : pk[31:0];
  assign exc    = (reset || !control) ? 1'b0  : pk[32];
endmodule

module multiplier import fp_alu_pkg::*; (
  input  logic        reset,
  input  logic        control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exc
);
  logic [47:0] prod;
  logic signed [10:0] e;
  logic        s, unused_bits;
  logic [32:0] pk;

  always_comb begin
    s    = a[31] ^ b[31];
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    unused_bits = ^prod[22:0];
    if (is_nan(a) || is_nan(b))                                       pk = {1'b1, FP_QNAN};
    else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))  pk = {1'b1, FP_QNAN};
    else if (is_inf(a) || is_inf(b))                                  pk = {1'b0, s, 8'hFF, 23'd0};
    else if (is_zero(a) || is_zero(b))                                pk = {1'b0, s, 31'd0};
    else if (prod[47])                                                pk = fp_pack(s, e + 11'sd1, prod[47:24]);
    else                                                              pk = fp_pack(s, e, prod[46:23]);
  end

  assign result = (reset || !control) ? 32'd0 : pk[31:0];
  assign exc    = (reset || !control) ? 1'b0  : pk[32];
endmodule

module divider import fp_alu_pkg::*; (
  input  logic        reset,
  input  logic        control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exc,
  output logic        zdiv
);
  logic [23:0] dv;
  logic [47:0] q;
  logic signed [10:0] e;
  logic        s, zd, unused_bits;
  logic [32:0] pk;

  always_comb begin
    s  = a[31] ^ b[31];
    // Divisor forced non-zero so the quotient path never divides by zero; the special cases cover it.
    dv = is_zero(b) ? 24'd1 : {1'b1, b[22:0]};
    q  = {1'b1, a[22:0], 24'd0} / {24'd0, dv};
    e  = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
    zd = 1'b0;
    unused_bits = ^q[47:25];
    if (is_nan(a) || is_nan(b))      pk = {1'b1, FP_QNAN};
    else if (is_inf(a))              pk = is_inf(b) ? {1'b1, FP_QNAN} : {1'b0, s, 8'hFF, 23'd0};
    else if (is_zero(b)) begin
      if (is_zero(a))                pk = {1'b1, FP_QNAN};
      else begin                     pk = {1'b0, s, 8'hFF, 23'd0}; zd = 1'b1; end
    end
    else if (is_inf(b) || is_zero(a)) pk = {1'b0, s, 31'd0};
    else if (q[24])                  pk = fp_pack(s, e, q[24:1]);
    else                             pk = fp_pack(s, e - 11'sd1, q[23:0]);
  end

  assign result = (reset || !control) ? 32'd0 : pk[31:0];
  assign exc    = (reset || !control) ? 1'b0  : pk[32];
  assign zdiv   = (reset || !control) ? 1'b0  : zd;
endmodule

// File: rtl/fp_alu_engine.sv
// Handshaked binary32 ALU: one command in flight, per-unit settle latency, tagged result FIFO.
// Define FP_ALU_MINMAX_EN to build the min/max comparator; otherwise ops 100/101 are illegal.
module fp_alu_engine import fp_alu_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_exc,
  output logic        out_zdiv,
  input  logic        flag_clr,
  output logic        sticky_exc,
  output logic        sticky_zdiv
);
  localparam int CW = 16;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sexc_q, szdiv_q, push;
  logic [AW:0]   count;
  entry_t        push_e, head;
  logic [31:0]   as_res, mu_res, dv_res;
  logic          as_exc, mu_exc, dv_exc, dv_zdiv;

  function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: return CW'(ADD_LAT - 1);
      OP_MUL:         return CW'(MUL_LAT - 1);
      OP_DIV:         return CW'(DIV_LAT - 1);
      default:        return '0;
    endcase
  endfunction

  add_sub    u_add (.reset(reset), .control(1'b1), .addsub(op_q == OP_SUB),
                    .a(a_q), .b(b_q), .result(as_res), .exc(as_exc));
  multiplier u_mul (.reset(reset), .control(1'b1), .a(a_q), .b(b_q),
                    .result(mu_res), .exc(mu_exc));
  divider    u_div (.reset(reset), .control(1'b1), .a(a_q), .b(b_q),
                    .result(dv_res), .exc(dv_exc), .zdiv(dv_zdiv));

`ifdef FP_ALU_MINMAX_EN
  logic [31:0] ka, kb, mm_res;
  logic        mm_exc, a_lt_b;

  // Map sign-magnitude to an unsigned key so -0 orders just below +0.
  always_comb begin
    ka     = a_q[31] ? ~a_q : {1'b1, a_q[30:0]};
    kb     = b_q[31] ? ~b_q : {1'b1, b_q[30:0]};
    a_lt_b = ka < kb;
    mm_exc = is_nan(a_q) || is_nan(b_q);
    if (mm_exc)          mm_res = FP_QNAN;
    else if (op_q[0])    mm_res = a_lt_b ? b_q : a_q;
    else                 mm_res = a_lt_b ? a_q : b_q;
  end
`endif

  always_comb begin
    push_e = '{32'd0, 1'b1, 1'b0};
    case (op_q)
      OP_ADD, OP_SUB: push_e = '{as_res, as_exc, 1'b0};
      OP_MUL:         push_e = '{mu_res, mu_exc, 1'b0};
      OP_DIV:         push_e = '{dv_res, dv_exc, dv_zdiv};
`ifdef FP_ALU_MINMAX_EN
      OP_MIN, OP_MAX: push_e = '{mm_res, mm_exc, 1'b0};
`else
      OP_MIN, OP_MAX: push_e = '{32'd0, 1'b1, 1'b0};
`endif
      default:        push_e = '{32'd0, 1'b1, 1'b0};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = (count < FULL);
        if (in_valid && in_ready) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = lat_m1(in_op);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sexc_q  <= 1'b0;
      szdiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      // A setting push beats a coincident clear.
      if (push && push_e.exc)  sexc_q <= 1'b1;
      else if (flag_clr)       sexc_q <= 1'b0;
      if (push && push_e.zdiv) szdiv_q <= 1'b1;
      else if (flag_clr)       szdiv_q <= 1'b0;
    end
  end

  fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(out_ready),
    .din(push_e), .head(head), .valid(out_valid), .count(count)
  );

  assign out_result  = head.result;
  assign out_exc     = head.exc;
  assign out_zdiv    = head.zdiv;
  assign sticky_exc  = sexc_q;
  assign sticky_zdiv = szdiv_q;
endmodule

// File: tb/tb_fp_alu_engine.sv
// Directed-vector bench for fp_alu_engine (DEPTH=4, ADD_LAT=1, MUL_LAT=2, DIV_LAT=4).
module tb_fp_alu_engine;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_exc, out_zdiv;
  logic        flag_clr, sticky_exc, sticky_zdiv;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  int          n_cmp = 0, n_bad = 0, lat_n;

  always #5 clk = ~clk;

  fp_alu_engine #(.DEPTH(4), .ADD_LAT(1), .MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc), .out_zdiv(out_zdiv), .flag_clr(flag_clr),
    .sticky_exc(sticky_exc), .sticky_zdiv(sticky_zdiv)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        exc, zdiv;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] bp[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: out_valid got 0, expected 1");
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    in_op = 3'b000; in_a = '0; in_b = '0;
    bp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    vecs.push_back('{3'b000, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b001, 32'h3FC00000, 32'h40100000, 32'hBF400000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b010, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 2});
    vecs.push_back('{3'b011, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 4});
    vecs.push_back('{3'b011, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 4});
`ifdef FP_ALU_MINMAX_EN
    vecs.push_back('{3'b100, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b101, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b101, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 1});
`else
    vecs.push_back('{3'b100, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{3'b101, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{3'b101, 32'h7FC00001, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, 1});
`endif
    vecs.push_back('{3'b110, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{3'b111, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{3'b000, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b010, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 2});
    vecs.push_back('{3'b010, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 2});
    vecs.push_back('{3'b000, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b011, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 4});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_out_zdiv", out_zdiv, 0);
    chk("rst_sticky_exc", sticky_exc, 0);
    chk("rst_sticky_zdiv", sticky_zdiv, 0);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat_n);
      chk($sformatf("v%0d_latency", i), lat_n, vecs[i].lat);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d_exc", i), out_exc, vecs[i].exc);
      chk($sformatf("v%0d_zdiv", i), out_zdiv, vecs[i].zdiv);
      pop();
    end

    // Sticky flags: accumulated, cleared alone, and set-wins against a coincident clear.
    chk("sticky_exc_accum", sticky_exc, 1);
    chk("sticky_zdiv_accum", sticky_zdiv, 1);
    flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
    chk("clr_sticky_exc", sticky_exc, 0);
    chk("clr_sticky_zdiv", sticky_zdiv, 0);
    send(3'b011, 32'h3F800000, 32'h00000000);
    repeat (3) @(negedge clk);
    flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
    chk("setwin_out_valid", out_valid, 1);
    chk("setwin_sticky_zdiv", sticky_zdiv, 1);
    chk("setwin_sticky_exc", sticky_exc, 0);
    pop();

    // Backpressure: four results fill the FIFO, the fifth waits for a pop.
    for (int k = 0; k < 4; k++) send(3'b000, bp[k], 32'h0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    in_op = 3'b000; in_a = bp[4]; in_b = 32'h0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_head", out_result, bp[0]);
    pop();
    chk("pop_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("drain%0d_valid", k), out_valid, 1);
      chk($sformatf("drain%0d_result", k), out_result, bp[k]);
      pop();
    end
    chk("drain_empty", out_valid, 0);

    // Reset during a divide with two entries queued.
    send(3'b110, 32'h0, 32'h0);
    send(3'b000, 32'h3F800000, 32'h3F800000);
    send(3'b011, 32'h40C00000, 32'h00000000);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sticky_exc", sticky_exc, 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sticky_exc", sticky_exc, 0);
    chk("midrst_sticky_zdiv", sticky_zdiv, 0);
    chk("midrst_out_result", out_result, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_push", out_valid, 0);
    chk("abort_sticky_zdiv", sticky_zdiv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
